// File: rtl/clk_meas_pkg.sv
// Shared definitions for the slow-clock/strobe period meter: FSM encoding and counter defaults.
package clk_meas_pkg;
  localparam int CNT_W_DEF = 16;
  localparam logic [CNT_W_DEF-1:0] CNT_SAT_DEF = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_MEAS = 2'd2
  } meas_state_e;
endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input, plus a delayed copy for edge detection.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q;
  logic              s_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d1   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      s_d1   <= sync_q[STAGES-1];
    end
  end

  assign s    = sync_q[STAGES-1];
  assign rise = s & ~s_d1;
  assign fall = ~s & s_d1;
endmodule

// File: rtl/clk_period_meter.sv
// Measures period / high time of a slow asynchronous strobe in clk cycles, with lock and overflow.
// Define DUTY_MEASURE_EN to build the high-time counter; otherwise high_time is tied to 0.
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4,
  parameter int TOL         = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  input  logic             clr_ovf,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             overflow
);
  localparam int               MW     = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] SAT    = {CNT_W{1'b1}};
  localparam logic [MW-1:0]    LOCK_M = MW'(LOCK_CNT);
  localparam logic [CNT_W:0]   TOL_W  = (CNT_W+1)'(TOL);

  meas_state_e      state_q, state_d;
  logic             s, rise, fall;
  logic [CNT_W-1:0] run_cnt;
  logic [MW-1:0]    match_q, match_inc;
  logic             first_q;
  logic             sat, start, done, step, hit;
  logic [CNT_W:0]   diff;
  logic             unused_sync;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .d(sig_in), .s(s), .rise(rise), .fall(fall)
  );

  assign unused_sync = ^{s, fall};

  always_comb begin
    sat   = en && (state_q == ST_MEAS) && (run_cnt == SAT);
    start = en && (state_q == ST_WAIT) && rise;
    // saturation beats a coincident rise
    done  = en && (state_q == ST_MEAS) && rise && !sat;
    step  = en && (state_q == ST_MEAS) && !rise && !sat;
    diff  = ({1'b0, run_cnt} >= {1'b0, period}) ? {1'b0, run_cnt} - {1'b0, period}
                                                  : {1'b0, period} - {1'b0, run_cnt};
    hit       = !first_q && (diff <= TOL_W);
    match_inc = (match_q == LOCK_M) ? match_q : match_q + 1'b1;
    state_d   = state_q;
    case (state_q)
      ST_IDLE: if (en)   state_d = ST_WAIT;
      ST_WAIT: if (rise) state_d = ST_MEAS;
      ST_MEAS: if (sat)  state_d = ST_WAIT;
      default:           state_d = ST_IDLE;
    endcase
    if (!en) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt  <= '0;
      match_q  <= '0;
      first_q  <= 1'b1;
      period   <= '0;
      valid    <= 1'b0;
      locked   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (clr_ovf) overflow <= 1'b0;
      if (sat) begin
        overflow <= 1'b1;
        locked   <= 1'b0;
        match_q  <= '0;
        run_cnt  <= '0;
      end else if (start) begin
        run_cnt <= CNT_W'(1);
        match_q <= '0;
        first_q <= 1'b1;
      end else if (done) begin
        period  <= run_cnt;
        valid   <= 1'b1;
        run_cnt <= CNT_W'(1);
        first_q <= 1'b0;
        if (hit) begin
          match_q <= match_inc;
          locked  <= (match_inc == LOCK_M);
        end else begin
          match_q <= '0;
          locked  <= 1'b0;
        end
      end else if (step) begin
        run_cnt <= run_cnt + 1'b1;
      end else if (!en || state_q == ST_IDLE) begin
        run_cnt <= '0;
        match_q <= '0;
        locked  <= 1'b0;
      end
    end
  end

`ifdef DUTY_MEASURE_EN
  logic [CNT_W-1:0] hi_cnt;

  // s only stays high from the rise until the fall, so adding s freezes the count after the fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt    <= '0;
      high_time <= '0;
    end else if (sat) begin
      hi_cnt <= '0;
    end else if (start) begin
      hi_cnt <= CNT_W'(1);
    end else if (done) begin
      high_time <= hi_cnt;
      hi_cnt    <= CNT_W'(1);
    end else if (step) begin
      hi_cnt <= hi_cnt + CNT_W'(s);
    end else if (!en || state_q == ST_IDLE) begin
      hi_cnt <= '0;
    end
  end
`else
  assign high_time = '0;
`endif
endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: three instances (default, CNT_W=4, TOL=1).
module tb_clk_period_meter;
  typedef struct { int p; int h; bit lk; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] en = '0, sig_in = '0, clr_ovf = '0;
  logic [15:0] period_a, high_a, period_c, high_c;
  logic [3:0]  period_b, high_b;
  logic valid_a, valid_b, valid_c, locked_a, locked_b, locked_c;
  logic ovf_a, ovf_b, ovf_c;
  exp_t q0[$], q1[$], q2[$];
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  clk_period_meter u_a (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .sig_in(sig_in[0]), .clr_ovf(clr_ovf[0]),
    .period(period_a), .high_time(high_a), .valid(valid_a), .locked(locked_a), .overflow(ovf_a));
  clk_period_meter #(.CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .sig_in(sig_in[1]), .clr_ovf(clr_ovf[1]),
    .period(period_b), .high_time(high_b), .valid(valid_b), .locked(locked_b), .overflow(ovf_b));
  clk_period_meter #(.TOL(1)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en[2]), .sig_in(sig_in[2]), .clr_ovf(clr_ovf[2]),
    .period(period_c), .high_time(high_c), .valid(valid_c), .locked(locked_c), .overflow(ovf_c));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int d, input int p, input int h, input bit lk);
    exp_t e;
    e.p = p;
    e.lk = lk;
`ifdef DUTY_MEASURE_EN
    e.h = h;
`else
    e.h = 0;
`endif
    if (d == 0) q0.push_back(e);
    else if (d == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask

  task automatic on_valid(input int d, input logic [15:0] p, input logic [15:0] h, input logic l);
    exp_t e;
    if (d == 0 && q0.size() > 0) e = q0.pop_front();
    else if (d == 1 && q1.size() > 0) e = q1.pop_front();
    else if (d == 2 && q2.size() > 0) e = q2.pop_front();
    else begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_valid dut%0d: got valid=1 period=%0d, expected no valid", d, p);
      return;
    end
    check($sformatf("period dut%0d", d), {16'd0, p}, e.p);
    check($sformatf("high_time dut%0d", d), {16'd0, h}, e.h);
    check($sformatf("locked dut%0d", d), {31'd0, l}, {31'd0, e.lk});
  endtask

  always @(negedge clk) begin
    if (valid_a === 1'b1) on_valid(0, period_a, high_a, locked_a);
    if (valid_b === 1'b1) on_valid(1, {12'd0, period_b}, {12'd0, high_b}, locked_b);
    if (valid_c === 1'b1) on_valid(2, period_c, high_c, locked_c);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // one period of the strobe starting with a rise; optional one-cycle en drop at index drop
  task automatic seg(input int d, input int p, input int h, input int drop);
    for (int i = 0; i < p; i++) begin
      sig_in[d] = (i < h);
      if (i == drop) en[d] = 1'b0;
      else if (drop >= 0 && i == drop + 1) en[d] = 1'b1;
      tick(1);
    end
  endtask

  initial begin
    tick(2);
    check("reset period", {16'd0, period_a}, 0);
    check("reset high_time", {16'd0, high_a}, 0);
    check("reset valid", {31'd0, valid_a}, 0);
    check("reset locked", {31'd0, locked_a}, 0);
    check("reset overflow", {29'd0, ovf_a, ovf_b, ovf_c}, 0);
    rst_n = 1'b1;

    // divide-by-3, then period 5 with two-cycle high
    en[0] = 1'b1;
    tick(3);
    for (int k = 0; k < 7; k++) begin push(0, 3, 1, k >= 4); seg(0, 3, 1, -1); end
    for (int k = 0; k < 6; k++) begin push(0, 5, 2, k >= 4); seg(0, 5, 2, -1); end
    // en drops mid-period: that period is discarded and lock is lost
    seg(0, 5, 2, 3);
    check("locked after en drop", {31'd0, locked_a}, 0);
    for (int k = 0; k < 6; k++) begin push(0, 5, 2, k >= 4); seg(0, 5, 2, -1); end
    seg(0, 5, 2, -1);
    tick(2);
    check("period before reset", {16'd0, period_a}, 5);
    check("locked before reset", {31'd0, locked_a}, 1);

    // async reset mid-measurement
    @(negedge clk); #1;
    rst_n = 1'b0;
    en = '0;
    sig_in = '0;
    #1;
    check("async period", {16'd0, period_a}, 0);
    check("async high_time", {16'd0, high_a}, 0);
    check("async locked", {31'd0, locked_a}, 0);
    check("async valid", {31'd0, valid_a}, 0);
    tick(1);
    rst_n = 1'b1;
    tick(10);

    // CNT_W=4 overflow on a stuck-low input
    en[1] = 1'b1;
    tick(3);
    sig_in[1] = 1'b1;
    tick(1);
    sig_in[1] = 1'b0;
    tick(16);
    check("overflow not yet", {31'd0, ovf_b}, 0);
    tick(1);
    check("overflow set", {31'd0, ovf_b}, 1);
    check("overflow locked", {31'd0, locked_b}, 0);
    clr_ovf[1] = 1'b1;
    tick(1);
    clr_ovf[1] = 1'b0;
    check("overflow cleared", {31'd0, ovf_b}, 0);
    sig_in[1] = 1'b1;
    tick(1);
    sig_in[1] = 1'b0;
    tick(16);
    clr_ovf[1] = 1'b1;
    check("overflow before 2nd sat", {31'd0, ovf_b}, 0);
    tick(1);
    clr_ovf[1] = 1'b0;
    check("overflow set beats clr", {31'd0, ovf_b}, 1);
    en[1] = 1'b0;
    tick(2);

    // TOL=1 with alternating 6/7 periods
    en[2] = 1'b1;
    tick(3);
    for (int j = 0; j < 6; j++) begin
      push(2, (j % 2) ? 7 : 6, 3, j >= 4);
      seg(2, (j % 2) ? 7 : 6, 3, -1);
    end
    seg(2, 6, 3, -1);
    tick(4);
    en = '0;
    tick(2);

    check("scoreboard dut0 drained", q0.size(), 0);
    check("scoreboard dut1 drained", q1.size(), 0);
    check("scoreboard dut2 drained", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
